// File: rtl/npc_predict.sv
`default_nettype none
// npc_predict: fetch PC register and next-PC prediction through a direct-mapped BTB with 2-bit counters.
// Optional build macro NPC_PERF_EN adds the resolved-branch and mispredict performance counters.
module npc_predict #(
   parameter int              PC_W     = 32,
   parameter int              ENTRIES  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            stall,
   output logic [PC_W-1:0] pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   input  logic            res_valid,
   input  logic [PC_W-1:0] res_pc,
   input  logic            res_uncond,
   input  logic            res_taken,
   input  logic [PC_W-1:0] res_target,
   input  logic            res_pred_taken,
   input  logic [PC_W-1:0] res_pred_tgt,
   output logic            flush,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispred
);
   localparam int              IDX_W  = $clog2(ENTRIES);
   localparam int              TAG_W  = PC_W - IDX_W - 2;
   localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

   logic [PC_W-1:0]    pc_q;
   logic [PC_W-1:0]    pc_next;
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [PC_W-1:0]    tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   logic [IDX_W-1:0]   ridx;
   logic [IDX_W-1:0]   widx;
   logic [TAG_W-1:0]   rtag;
   logic [TAG_W-1:0]   wtag;
   logic               rhit;
   logic               whit;
   logic               mispred;

   logic               wr_alloc;
   logic               wr_tgt;
   logic               ctr_wr;
   logic [1:0]         ctr_new;

   assign ridx = pc_q[IDX_W+1:2];
   assign rtag = pc_q[PC_W-1:IDX_W+2];
   assign widx = res_pc[IDX_W+1:2];
   assign wtag = res_pc[PC_W-1:IDX_W+2];

   // Lookup reads the registered arrays, so a same-cycle update is seen one cycle later.
   assign rhit        = valid_q[ridx] && (tag_q[ridx] == rtag);
   assign whit        = valid_q[widx] && (tag_q[widx] == wtag);
   assign pred_taken  = rhit && ctr_q[ridx][1];
   assign pred_target = pred_taken ? tgt_q[ridx] : pc_q + PC_INC;
   assign pc          = pc_q;

   assign mispred = res_valid &&
                    ((res_taken != res_pred_taken) ||
                     (res_taken && (res_target != res_pred_tgt)));
   assign flush   = mispred;

   always_comb begin
      pc_next = pred_target;
      if (mispred) begin
         pc_next = res_taken ? res_target : res_pc + PC_INC;
      end else if (stall) begin
         pc_next = pc_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   always_comb begin
      wr_alloc = 1'b0;
      wr_tgt   = 1'b0;
      ctr_wr   = 1'b0;
      ctr_new  = ctr_q[widx];
      if (res_valid) begin
         if (res_uncond) begin
            wr_alloc = 1'b1;
            wr_tgt   = 1'b1;
            ctr_wr   = 1'b1;
            ctr_new  = 2'b11;
         end else if (whit) begin
            ctr_wr = 1'b1;
            wr_tgt = res_taken;
            if (res_taken) begin
               ctr_new = (ctr_q[widx] == 2'b11) ? 2'b11 : ctr_q[widx] + 2'd1;
            end else begin
               ctr_new = (ctr_q[widx] == 2'b00) ? 2'b00 : ctr_q[widx] - 2'd1;
            end
         end else if (res_taken) begin
            // A taken miss replaces whatever branch occupied the slot.
            wr_alloc = 1'b1;
            wr_tgt   = 1'b1;
            ctr_wr   = 1'b1;
            ctr_new  = 2'b10;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else begin
         if (wr_alloc) begin
            valid_q[widx] <= 1'b1;
         end
         if (ctr_wr) begin
            ctr_q[widx] <= ctr_new;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (wr_alloc) begin
            tag_q[widx] <= wtag;
         end
         if (wr_tgt) begin
            tgt_q[widx] <= res_target;
         end
      end
   end

`ifdef NPC_PERF_EN
   logic [31:0] perf_br_q;
   logic [31:0] perf_mp_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_br_q <= '0;
         perf_mp_q <= '0;
      end else begin
         if (res_valid) begin
            perf_br_q <= perf_br_q + 32'd1;
         end
         if (mispred) begin
            perf_mp_q <= perf_mp_q + 32'd1;
         end
      end
   end

   assign perf_branches = perf_br_q;
   assign perf_mispred  = perf_mp_q;
`else
   assign perf_branches = '0;
   assign perf_mispred  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_npc_predict.sv
`default_nettype none
// tb_npc_predict: directed scenarios followed by random traffic, scored against a behavioural BTB model.
module tb_npc_predict;
   localparam int ENTRIES = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        stall = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic        res_uncond = 1'b0;
   logic        res_taken = 1'b0;
   logic [31:0] res_target = '0;
   logic        res_pred_taken = 1'b0;
   logic [31:0] res_pred_tgt = '0;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        flush;
   logic [31:0] perf_branches;
   logic [31:0] perf_mispred;

   npc_predict #(.PC_W(32), .ENTRIES(ENTRIES), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RST(RST), .stall(stall),
      .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .res_valid(res_valid), .res_pc(res_pc), .res_uncond(res_uncond),
      .res_taken(res_taken), .res_target(res_target),
      .res_pred_taken(res_pred_taken), .res_pred_tgt(res_pred_tgt),
      .flush(flush), .perf_branches(perf_branches), .perf_mispred(perf_mispred)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      logic [31:0] pb;
      logic [31:0] pm;
   } exp_t;

   exp_t expq[$];
   int   compared = 0;
   int   mismatched = 0;

   // Reference model: one record per BTB slot, counters as plain integers 0..3.
   bit          m_valid[ENTRIES];
   bit [31:0]   m_tag[ENTRIES];
   bit [31:0]   m_tgt[ENTRIES];
   int          m_ctr[ENTRIES];
   bit [31:0]   m_pc;
   bit [31:0]   m_pb;
   bit [31:0]   m_pm;

   function automatic int slot(input bit [31:0] a);
      return int'((a >> 2) % ENTRIES);
   endfunction

   function automatic bit [31:0] tagof(input bit [31:0] a);
      return a / 32'(4 * ENTRIES);
   endfunction

   function automatic void m_reset();
      m_pc = 32'h0;
      m_pb = 32'h0;
      m_pm = 32'h0;
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
   endfunction

   function automatic bit m_lookup(input bit [31:0] a, output bit [31:0] t);
      int e;
      bit take;
      e    = slot(a);
      take = m_valid[e] && (m_tag[e] == tagof(a)) && (m_ctr[e] >= 2);
      t    = take ? m_tgt[e] : a + 32'd4;
      return take;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
      end
   endtask

   // Drives one cycle of inputs, records the expected outputs, then advances the model.
   task automatic step(input bit rst, input bit st, input bit rv, input bit unc, input bit tk,
                       input bit [31:0] rpc, input bit [31:0] rtgt,
                       input bit rpt, input bit [31:0] rptgt);
      exp_t      e;
      bit        pt;
      bit [31:0] ptgt;
      bit        mp;
      int        w;
      bit        hit;
      RST = rst; stall = st; res_valid = rv; res_uncond = unc; res_taken = tk;
      res_pc = rpc; res_target = rtgt; res_pred_taken = rpt; res_pred_tgt = rptgt;
      pt = m_lookup(m_pc, ptgt);
      mp = rv && ((tk != rpt) || (tk && (rtgt != rptgt)));
      e.pc = m_pc; e.pt = pt; e.ptgt = ptgt; e.fl = mp;
`ifdef NPC_PERF_EN
      e.pb = m_pb; e.pm = m_pm;
`else
      e.pb = 32'h0; e.pm = 32'h0;
`endif
      expq.push_back(e);
      if (rst) begin
         m_reset();
      end else begin
         if (rv) m_pb = m_pb + 32'd1;
         if (mp) m_pm = m_pm + 32'd1;
         if (mp)      m_pc = tk ? rtgt : rpc + 32'd4;
         else if (!st) m_pc = ptgt;
         if (rv) begin
            w   = slot(rpc);
            hit = m_valid[w] && (m_tag[w] == tagof(rpc));
            if (unc) begin
               m_valid[w] = 1'b1; m_tag[w] = tagof(rpc); m_tgt[w] = rtgt; m_ctr[w] = 3;
            end else if (hit) begin
               if (tk) begin
                  m_ctr[w] = (m_ctr[w] == 3) ? 3 : m_ctr[w] + 1;
                  m_tgt[w] = rtgt;
               end else begin
                  m_ctr[w] = (m_ctr[w] == 0) ? 0 : m_ctr[w] - 1;
               end
            end else if (tk) begin
               m_valid[w] = 1'b1; m_tag[w] = tagof(rpc); m_tgt[w] = rtgt; m_ctr[w] = 2;
            end
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input bit st);
      step(1'b0, st, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("pc", pc, e.pc);
         chk("pred_taken", 32'(pred_taken), 32'(e.pt));
         chk("pred_target", pred_target, e.ptgt);
         chk("flush", 32'(flush), 32'(e.fl));
         chk("perf_branches", perf_branches, e.pb);
         chk("perf_mispred", perf_mispred, e.pm);
      end
   end

   function automatic bit [31:0] pick_pc();
      case ($urandom_range(0, 5))
         0: return 32'h8;
         1: return 32'h10;
         2: return 32'h50;
         3: return 32'hFFFF_FFFC;
         default: return $urandom() & 32'h0000_03FC;
      endcase
   endfunction

   function automatic bit [31:0] pick_tgt();
      case ($urandom_range(0, 4))
         0: return 32'h40;
         1: return 32'h80;
         2: return 32'hFFFF_FFFC;
         default: return $urandom() & 32'h0000_03FC;
      endcase
   endfunction

   initial begin
      bit        unc, tk, rv, rpt;
      bit [31:0] rpc, rtgt, rptgt;
      int        mode;
      @(posedge CLK);
      #1;
      m_reset();
      // Sequential fetch from reset.
      idle(1'b0); idle(1'b0);
      // Taken branch at 0x8 predicted not taken.
      step(0, 0, 1, 0, 1, 32'h8, 32'h40, 0, 32'hC);
      idle(1'b0);
      step(0, 0, 1, 1, 1, 32'h44, 32'h8, 0, 32'h48);
      idle(1'b0);
      // Two not-taken reports at 0x8 walk the counter down.
      step(0, 0, 1, 0, 0, 32'h8, 32'h0, 1, 32'h40);
      step(0, 0, 1, 1, 1, 32'h4C, 32'h8, 0, 32'h50);
      step(0, 0, 1, 0, 0, 32'h8, 32'h0, 0, 32'hC);
      step(0, 0, 1, 1, 1, 32'h3C, 32'h8, 0, 32'h40);
      idle(1'b0);
      // Mispredict overrides stall; stall alone holds.
      step(0, 1, 1, 0, 1, 32'h20, 32'h100, 0, 32'h24);
      idle(1'b1); idle(1'b1); idle(1'b0);
      // Aliasing JRs at 0x10 and 0x50.
      step(0, 0, 1, 1, 1, 32'h10, 32'h80, 0, 32'h14);
      step(0, 0, 1, 1, 1, 32'h50, 32'h80, 1, 32'h80);
      step(0, 0, 1, 0, 1, 32'h90, 32'h10, 0, 32'h94);
      idle(1'b0);
      // Reset arriving together with a report.
      step(1, 0, 1, 1, 1, 32'h8, 32'h200, 0, 32'hC);
      idle(1'b0); idle(1'b0);

      for (int n = 0; n < 3000; n++) begin
         rv  = ($urandom_range(0, 2) != 0);
         unc = ($urandom_range(0, 3) == 0);
         tk  = unc ? 1'b1 : bit'($urandom_range(0, 1));
         rpc  = pick_pc();
         rtgt = pick_tgt();
         mode = $urandom_range(0, 3);
         if (mode < 2) begin
            rpt = m_lookup(rpc, rptgt);
         end else if (mode == 2) begin
            rpt = tk; rptgt = rtgt;
         end else begin
            rpt = bit'($urandom_range(0, 1)); rptgt = pick_tgt();
         end
         step(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 4) == 0),
              rv, unc, tk, rpc, rtgt, rpt, rptgt);
      end
      idle(1'b0);
      @(negedge CLK);
      @(negedge CLK);
      chk("queue_drained", 32'(expq.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
